// File: rtl/rotate_issue_fifo.sv
// Request FIFO feeding a registered circular-right-rotate output stage.
// Valid/ready on both sides; the output register is refilled from the FIFO head.
module rotate_issue_fifo #(
    parameter int WIDTH = 4,
    parameter int KW    = $clog2(WIDTH),
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [KW-1:0]              in_k,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] data;
    } req_t;

    req_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_push;
    logic             w_pop;
    req_t             w_head;
    logic [KW-1:0]    w_idx;
    logic [WIDTH-1:0] w_rot;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign in_ready = (r_count != CW'(DEPTH));
    assign w_push   = in_valid & in_ready;
    assign w_pop    = (r_count != '0) & (~r_out_valid | out_ready);
    assign w_head   = r_mem[r_rd_ptr];

    // Bit i takes data bit (i+k) mod WIDTH; the KW-bit sum wraps for free.
    always_comb begin
        w_rot = '0;
        w_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_idx    = KW'(i) + w_head.k;
            w_rot[i] = w_head.data[w_idx];
        end
    end

    // NOTE: storage has no reset; only the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{k: in_k, data: in_data};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_rot;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;

endmodule
